f1_light_seq: RTL and testbench

F1_LIGHT_SEQ -- requirements
Module: f1_light_seq

---
 rtl/f1_pkg.sv | 24 ++
 rtl/f1_lfsr.sv | 28 ++
 rtl/f1_light_seq.sv | 146 ++++++++++++++
 tb/tb_f1_light_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/f1_pkg.sv
// f1_pkg: shared types and constants for the F1 start-light sequencer.
//   state_t    - sequencer states (IDLE, FILL, HOLD)
//   LFSR_W     - width of the random-hold LFSR
//   LFSR_TAP   - feedback tap mask for x^7 + x^6 + 1
//   CNT_W      - width of the hold counter (holds 0..16)
//   lfsr_step  - one Fibonacci step of the LFSR
package f1_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int unsigned LFSR_W   = 7;
    localparam logic [LFSR_W-1:0] LFSR_TAP = 7'h60;
    localparam int unsigned CNT_W    = 5;

    // Shift left, feeding back the XOR of the tapped bits (q[6] ^ q[5]).
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], ^(q & LFSR_TAP)};
    endfunction

endpackage

// File: rtl/f1_lfsr.sv
// f1_lfsr: free-running 7-bit maximal-length LFSR (x^7 + x^6 + 1).
// Ports:
//   clk   - clock, steps on every rising edge
//   rst   - synchronous active-high reset, loads seed
//   seed  - reset value (caller guarantees non-zero)
//   q     - current LFSR state
import f1_pkg::*;

module f1_lfsr (
    input  logic              clk,
    input  logic              rst,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= seed;
        end else begin
            r_q <= lfsr_step(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/f1_light_seq.sv
// f1_light_seq: F1 start-light sequencer. A trigger lights the first lamp,
// each enabled tick lights one more, all lamps stay on for H ticks, then all
// drop together with a one-clock lights_out pulse.
// Optional feature: define F1_RANDOM_HOLD_EN to draw H from an LFSR
// (LFSR[3:0]+1) instead of the fixed HOLD_TICKS.
// Ports:
//   clk        - sole clock
//   rst        - synchronous active-high reset
//   en         - tick enable for fill/hold progress
//   trigger    - start request (not gated by en)
//   data_out   - light pattern, bit 0 is the first light
//   busy       - high while filling or holding
//   lights_out - one-clock pulse when all lights drop
import f1_pkg::*;

module f1_light_seq #(
    parameter int unsigned       N_LIGHTS   = 8,
    parameter int unsigned       HOLD_TICKS = 4,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 7'h01
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                trigger,
    output logic [N_LIGHTS-1:0] data_out,
    output logic                busy,
    output logic                lights_out
);

    localparam logic [N_LIGHTS-1:0] ALL_ON    = '1;
    localparam logic [N_LIGHTS-1:0] FIRST_ON  = N_LIGHTS'(1);

    // Elaboration-time parameter legality check.
    if (N_LIGHTS < 2 || N_LIGHTS > 16 || HOLD_TICKS < 1 || HOLD_TICKS > 16 ||
        $bits(LFSR_SEED) != LFSR_W) begin : g_bad_param
        $error("f1_light_seq: illegal parameter value");
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N_LIGHTS-1:0] r_data;
    logic [N_LIGHTS-1:0] w_data_nxt;
    logic [N_LIGHTS-1:0] w_fill;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0]    w_hold_load;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_lo;
    logic                w_lo_nxt;
    logic                w_start;
    logic                w_fill_done;
    logic                w_hold_done;

`ifdef F1_RANDOM_HOLD_EN
    // A zero seed would lock the LFSR up, so it is replaced by 1.
    localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

    logic [LFSR_W-1:0] w_lfsr;

    f1_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (SEED_EFF),
        .q    (w_lfsr)
    );

    assign w_hold_load = CNT_W'(w_lfsr[3:0]) + CNT_W'(1);
`else
    assign w_hold_load = CNT_W'(HOLD_TICKS);
`endif

    // A trigger coinciding with the lights_out pulse is dropped.
    assign w_start     = trigger & ~r_lo;
    assign w_fill      = {r_data[N_LIGHTS-2:0], 1'b1};
    assign w_fill_done = en & (w_fill == ALL_ON);
    assign w_hold_done = en & (r_cnt == CNT_W'(1));

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_lo    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start)     w_state_nxt = FILL;
            FILL:    if (w_fill_done) w_state_nxt = HOLD;
            HOLD:    if (w_hold_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values for the registered outputs and hold counter.
    always_comb begin
        w_data_nxt = r_data;
        w_cnt_nxt  = r_cnt;
        w_lo_nxt   = 1'b0;
        w_busy_nxt = (w_state_nxt != IDLE);
        case (r_state)
            IDLE: begin
                w_data_nxt = w_start ? FIRST_ON : '0;
            end
            FILL: begin
                if (en) begin
                    w_data_nxt = w_fill;
                end
                if (w_fill_done) begin
                    w_cnt_nxt = w_hold_load;
                end
            end
            HOLD: begin
                w_data_nxt = ALL_ON;
                if (w_hold_done) begin
                    w_data_nxt = '0;
                    w_cnt_nxt  = '0;
                    w_lo_nxt   = 1'b1;
                end else if (en) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_data_nxt = '0;
                w_cnt_nxt  = '0;
            end
        endcase
    end

    assign data_out   = r_data;
    assign busy       = r_busy;
    assign lights_out = r_lo;

endmodule

// File: tb/tb_f1_light_seq.sv
// tb_f1_light_seq: directed self-checking bench for f1_light_seq.
// Instance dut (N_LIGHTS=8) covers the main sequence, stall, reset-abort and
// trigger-on-pulse cases; dut4 (N_LIGHTS=4) covers sparse enable ticks.
// With F1_RANDOM_HOLD_EN defined, dut runs 50 random-hold sequences instead.
`timescale 1ns/1ps

module tb_f1_light_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, trigger;
    logic [7:0] data_out;
    logic       busy, lights_out;
    logic       en4, trigger4;
    logic [3:0] data_out4;
    logic       busy4, lights_out4;

    int n_chk = 0;
    int n_err = 0;

    logic [6:0] ref_lfsr;
    logic [6:0] prev_lfsr;

    always #5 clk = ~clk;

    f1_light_seq #(.N_LIGHTS(8), .HOLD_TICKS(4), .LFSR_SEED(7'h01)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .trigger    (trigger),
        .data_out   (data_out),
        .busy       (busy),
        .lights_out (lights_out)
    );

    f1_light_seq #(.N_LIGHTS(4), .HOLD_TICKS(4), .LFSR_SEED(7'h01)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .en         (en4),
        .trigger    (trigger4),
        .data_out   (data_out4),
        .busy       (busy4),
        .lights_out (lights_out4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the reference LFSR with the edge, then settle 1ns.
    task automatic tick();
        prev_lfsr = ref_lfsr;
        @(posedge clk);
        ref_lfsr = rst ? 7'h01 : {ref_lfsr[5:0], ref_lfsr[6] ^ ref_lfsr[5]};
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; trigger = 1'b0; en4 = 1'b0; trigger4 = 1'b0;
        ref_lfsr = 7'h01; prev_lfsr = 7'h01;
        @(negedge clk);
        // Reset wins over trigger/en.
        en = 1'b1; trigger = 1'b1;
        tick(); tick();
        rst = 1'b0; trigger = 1'b0; en = 1'b0;
        check("rst_data", 32'(data_out), 32'h00);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_lo",   32'(lights_out), 32'h0);
        check("rst_data4", 32'(data_out4), 32'h0);

`ifdef F1_RANDOM_HOLD_EN
        begin
            logic [15:0] seen;
            int          n_distinct;
            int          h_exp, h_meas, budget;
            seen = '0;
            en = 1'b1;
            for (int s = 0; s < 50; s++) begin
                trigger = 1'b1;
                tick();
                trigger = 1'b0;
                check("rnd_first", 32'(data_out), 32'h01);
                budget = 0;
                while (data_out != 8'hFF && budget < 20) begin
                    tick(); budget++;
                end
                check("rnd_fill_timeout", 32'(budget < 20), 32'h1);
                h_exp  = int'(prev_lfsr[3:0]) + 1;
                h_meas = 0;
                budget = 0;
                while (data_out == 8'hFF && budget < 20) begin
                    h_meas++; tick(); budget++;
                end
                check("rnd_hold_len", 32'(h_meas), 32'(h_exp));
                check("rnd_range", 32'(h_meas >= 1 && h_meas <= 16), 32'h1);
                check("rnd_lo", 32'(lights_out), 32'h1);
                if (h_meas >= 1 && h_meas <= 16) seen[h_meas-1] = 1'b1;
            end
            n_distinct = $countones(seen);
            check("rnd_distinct", 32'(n_distinct >= 2), 32'h1);
            en = 1'b0;
        end
`else
        // Continuous en: first light after one clk, one light per clk after that.
        en = 1'b1; trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check("seq_first", 32'(data_out), 32'h01);
        check("seq_busy",  32'(busy), 32'h1);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("seq_fill", 32'(data_out), 32'((1 << (i + 1)) - 1));
            check("seq_fill_lo", 32'(lights_out), 32'h0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            check("seq_hold", 32'(data_out), 32'hFF);
            check("seq_hold_busy", 32'(busy), 32'h1);
            check("seq_hold_lo", 32'(lights_out), 32'h0);
        end
        tick();
        check("seq_out_data", 32'(data_out), 32'h00);
        check("seq_out_lo",   32'(lights_out), 32'h1);
        check("seq_out_busy", 32'(busy), 32'h0);
        // Trigger during the lights_out cycle is ignored.
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check("lotrig_data", 32'(data_out), 32'h00);
        check("lotrig_busy", 32'(busy), 32'h0);
        check("lotrig_lo",   32'(lights_out), 32'h0);
        tick();
        check("lotrig_data2", 32'(data_out), 32'h00);

        // Stalled fill: en low, extra triggers ignored.
        en = 1'b0; trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check("stall_first", 32'(data_out), 32'h01);
        for (int i = 0; i < 20; i++) begin
            trigger = (i % 4 == 1);
            tick();
            check("stall_data", 32'(data_out), 32'h01);
            check("stall_busy", 32'(busy), 32'h1);
        end
        trigger = 1'b0; en = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("stall_end_hold", 32'(data_out), 32'hFF);
        tick();
        check("stall_end_lo",   32'(lights_out), 32'h1);
        check("stall_end_data", 32'(data_out), 32'h00);
        tick();

        // Reset during HOLD aborts without a lights_out pulse.
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("abort_pre", 32'(data_out), 32'hFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_data", 32'(data_out), 32'h00);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_lo",   32'(lights_out), 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_nolo", 32'(lights_out), 32'h0);
            check("abort_idle", 32'(data_out), 32'h00);
        end
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check("abort_restart", 32'(data_out), 32'h01);
        en = 1'b0;

        // N_LIGHTS=4, en every 3rd clk.
        begin
            int         e;
            logic [3:0] exp_d;
            trigger4 = 1'b1;
            tick();
            trigger4 = 1'b0;
            check("sparse_first", 32'(data_out4), 32'h1);
            e = 0;
            for (int k = 0; k < 21; k++) begin
                en4 = (k % 3 == 2);
                tick();
                if (en4) e++;
                if (e >= 7)      exp_d = 4'h0;
                else if (e >= 3) exp_d = 4'hF;
                else             exp_d = 4'((1 << (e + 1)) - 1);
                check("sparse_data", 32'(data_out4), 32'(exp_d));
                check("sparse_lo",   32'(lights_out4), 32'(en4 && e == 7));
                check("sparse_busy", 32'(busy4), 32'(e < 7));
            end
            en4 = 1'b0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
